// File: rtl/tx_framer.sv
// tx_framer
//   Transmit-side framer for a 16-bit 8b10b transceiver link. Payload is
//   taken from either the SIM or ROC source. Each packet is wrapped in SOP/EOP
//   control words. Idle time, bubbles and inter-packet gaps are filled with
//   the comma word.
//
//   Handshake: a source word transfers on a TX_CLK edge where VALID and READY
//   are both 1. READY depends only on the state register, never on VALID.
//   A source holds DATA/LAST stable while VALID is 1 and READY is 0.
//
// Ports
//   TX_CLK, TX_RST      clock and synchronous active-high reset
//   SIM_EN              source select (1=SIM, 0=ROC); only looked at in IDLE
//   LINK_ALIGNED        new packets start only while 1
//   SIM_* / ROC_*       payload streams (DATA, VALID, LAST in; READY out)
//   TX_DATA, TX_K_CHAR  registered word and K flags to the transceiver
//   TX_BUSY             1 whenever the FSM is not in IDLE
//   PKT_CNT             count of EOP words sent (wraps)
//   TRUNC_ERR           sticky flag: a packet was cut at MAX_LEN words
module tx_framer #(
  parameter logic [15:0] COMMA    = 16'hBC3C,
  parameter logic [15:0] SOP_WORD = 16'h1C3C,
  parameter logic [15:0] EOP_WORD = 16'hFC3C,
  parameter int          MIN_GAP  = 4,
  parameter int          MAX_LEN  = 256
) (
  input  logic        TX_CLK,
  input  logic        TX_RST,
  input  logic        SIM_EN,
  input  logic        LINK_ALIGNED,
  input  logic [15:0] SIM_DATA,
  input  logic        SIM_VALID,
  input  logic        SIM_LAST,
  output logic        SIM_READY,
  input  logic [15:0] ROC_DATA,
  input  logic        ROC_VALID,
  input  logic        ROC_LAST,
  output logic        ROC_READY,
  output logic [15:0] TX_DATA,
  output logic [1:0]  TX_K_CHAR,
  output logic        TX_BUSY,
  output logic [15:0] PKT_CNT,
  output logic        TRUNC_ERR
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DATA  = 3'd1,
    S_EOP   = 3'd2,
    S_EOP_T = 3'd3,
    S_DRAIN = 3'd4,
    S_GAP   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               sel_q, sel_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [15:0]        tx_data_q, tx_data_d;
  logic [1:0]         tx_k_q, tx_k_d;
  logic [15:0]        pkt_cnt_q, pkt_cnt_d;
  logic               trunc_q, trunc_d;

  // Stream of the source latched for the current packet.
  logic        src_valid;
  logic        src_last;
  logic [15:0] src_data;
  // VALID of the source SIM_EN points at right now (used only to start).
  logic        start_valid;
  logic        rd_state;

  assign src_valid   = sel_q ? SIM_VALID : ROC_VALID;
  assign src_last    = sel_q ? SIM_LAST  : ROC_LAST;
  assign src_data    = sel_q ? SIM_DATA  : ROC_DATA;
  assign start_valid = SIM_EN ? SIM_VALID : ROC_VALID;

  // Words are consumed in DATA and (discarded) in DRAIN.
  assign rd_state  = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign SIM_READY = rd_state && sel_q;
  assign ROC_READY = rd_state && !sel_q;
  assign TX_BUSY   = (state_q != S_IDLE);

  assign TX_DATA   = tx_data_q;
  assign TX_K_CHAR = tx_k_q;
  assign PKT_CNT   = pkt_cnt_q;
  assign TRUNC_ERR = trunc_q;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    len_d     = len_q;
    gap_d     = gap_q;
    pkt_cnt_d = pkt_cnt_q;
    trunc_d   = trunc_q;
    tx_data_d = COMMA;
    tx_k_d    = 2'b11;

    case (state_q)
      S_IDLE: begin
        if (LINK_ALIGNED && start_valid) begin
          sel_d     = SIM_EN;
          tx_data_d = SOP_WORD;
          len_d     = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (src_valid) begin
          tx_data_d = src_data;
          tx_k_d    = 2'b00;
          len_d     = len_q + LEN_W'(1);
          // LAST wins over truncation when the MAX_LEN-th word is also last.
          if (src_last) begin
            state_d = S_EOP;
          end else if (len_q == LEN_W'(MAX_LEN - 1)) begin
            trunc_d = 1'b1;
            state_d = S_EOP_T;
          end
        end
      end
      S_EOP, S_EOP_T: begin
        tx_data_d = EOP_WORD;
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        gap_d     = '0;
        state_d   = (state_q == S_EOP) ? S_GAP : S_DRAIN;
      end
      S_DRAIN: begin
        // Remainder of a truncated packet is swallowed up to its LAST.
        if (src_valid && src_last) begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(MIN_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge TX_CLK) begin
    if (TX_RST) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      len_q     <= '0;
      gap_q     <= '0;
      tx_data_q <= COMMA;
      tx_k_q    <= 2'b11;
      pkt_cnt_q <= 16'd0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      tx_data_q <= tx_data_d;
      tx_k_q    <= tx_k_d;
      pkt_cnt_q <= pkt_cnt_d;
      trunc_q   <= trunc_d;
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// Bench for tx_framer (built with MAX_LEN=4, MIN_GAP=4).
module tb_tx_framer;

  localparam logic [15:0] COMMA    = 16'hBC3C;
  localparam logic [15:0] SOP_WORD = 16'h1C3C;
  localparam logic [15:0] EOP_WORD = 16'hFC3C;
  localparam int          MIN_GAP  = 4;
  localparam int          MAX_LEN  = 4;

  logic        clk = 1'b0;
  logic        tx_rst;
  logic        sim_en, link_aligned;
  logic [15:0] sim_data, roc_data;
  logic        sim_valid, sim_last, sim_ready;
  logic        roc_valid, roc_last, roc_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic        tx_busy;
  logic [15:0] pkt_cnt;
  logic        trunc_err;

  int checks = 0;
  int errors = 0;

  // Expected stream of non-comma words, {K flags, data}.
  logic [17:0] exp_q[$];
  int          exp_pkt   = 0;
  logic        exp_trunc = 1'b0;
  logic        mon_en    = 1'b1;

  tx_framer #(.MIN_GAP(MIN_GAP), .MAX_LEN(MAX_LEN)) dut (
    .TX_CLK(clk), .TX_RST(tx_rst), .SIM_EN(sim_en), .LINK_ALIGNED(link_aligned),
    .SIM_DATA(sim_data), .SIM_VALID(sim_valid), .SIM_LAST(sim_last), .SIM_READY(sim_ready),
    .ROC_DATA(roc_data), .ROC_VALID(roc_valid), .ROC_LAST(roc_last), .ROC_READY(roc_ready),
    .TX_DATA(tx_data), .TX_K_CHAR(tx_k), .TX_BUSY(tx_busy),
    .PKT_CNT(pkt_cnt), .TRUNC_ERR(trunc_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a packet of n words base, base+1, ... appears on the
  // link as SOP, the first min(n, MAX_LEN) words, EOP.
  task automatic model_pkt(input logic [15:0] base, input int n);
    exp_q.push_back({2'b11, SOP_WORD});
    for (int i = 0; i < n && i < MAX_LEN; i++)
      exp_q.push_back({2'b00, base + 16'(i)});
    exp_q.push_back({2'b11, EOP_WORD});
    exp_pkt++;
    if (n > MAX_LEN) exp_trunc = 1'b1;
  endtask

  task automatic drive_src(input bit src, input bit v, input logic [15:0] d, input bit l);
    if (src) begin sim_valid = v; sim_data = d; sim_last = l; end
    else     begin roc_valid = v; roc_data = d; roc_last = l; end
  endtask

  // Driver: sends one packet from src with random bubbles, records it in the model.
  task automatic send_pkt(input bit src, input int n, input logic [15:0] base, input int max_bub);
    bit acc;
    int t;
    model_pkt(base, n);
    sim_en = src;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_bub)) begin
        @(negedge clk); drive_src(src, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
      end
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        drive_src(src, 1'b1, base + 16'(i), (i == n - 1));
        acc = src ? sim_ready : roc_ready;
        @(posedge clk);
        t++;
      end
      if (!acc) chk("send_timeout", 32'(i), 32'hFFFF_FFFF);
    end
    @(negedge clk); drive_src(src, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); t++;
    end
    chk("sb_drain", exp_q.size(), 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int   comma_run = 0;
    bit   seen_eop  = 1'b0;
    logic [17:0] got, exp;
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        chk("ready_exclusive", {sim_ready, roc_ready} == 2'b11, 0);
        got = {tx_k, tx_data};
        if (got == {2'b11, COMMA}) begin
          comma_run++;
        end else begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected actual=%h expected=none", got);
          end else begin
            exp = exp_q.pop_front();
            chk("sb_word", got, exp);
          end
          if (got == {2'b11, SOP_WORD} && seen_eop)
            chk("gap_len_ok", comma_run >= MIN_GAP, 1);
          if (got == {2'b11, EOP_WORD}) seen_eop = 1'b1;
          comma_run = 0;
        end
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] d;
    logic [15:0] ed;
    logic [1:0]  ek;
    logic        er;
    logic        eb;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // 3-word ROC packet, then 2-word packet with a 2-cycle bubble.
    tbl[0]  = '{1'b1, 1'b0, 16'h0001, SOP_WORD,  2'b11, 1'b1, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0001, 16'h0001,  2'b00, 1'b1, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0002, 16'h0002,  2'b00, 1'b1, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 16'h0003, 16'h0003,  2'b00, 1'b0, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, EOP_WORD,  2'b11, 1'b0, 1'b1, 16'd1};
    for (int i = 5; i <= 8; i++)
      tbl[i] = '{1'b0, 1'b0, 16'h0000, COMMA, 2'b11, 1'b0, (i != 8), 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0010, SOP_WORD,  2'b11, 1'b1, 1'b1, 16'd1};
    tbl[10] = '{1'b1, 1'b0, 16'h0010, 16'h0010,  2'b00, 1'b1, 1'b1, 16'd1};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, COMMA,     2'b11, 1'b1, 1'b1, 16'd1};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, COMMA,     2'b11, 1'b1, 1'b1, 16'd1};
    tbl[13] = '{1'b1, 1'b1, 16'h0011, 16'h0011,  2'b00, 1'b0, 1'b1, 16'd1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, EOP_WORD,  2'b11, 1'b0, 1'b1, 16'd2};
    for (int i = 15; i <= 18; i++)
      tbl[i] = '{1'b0, 1'b0, 16'h0000, COMMA, 2'b11, 1'b0, (i != 18), 16'd2};
  end

  // ---------------- main sequence ----------------
  initial begin
    tx_rst = 1'b1; sim_en = 1'b0; link_aligned = 1'b1;
    sim_data = '0; sim_valid = 1'b0; sim_last = 1'b0;
    roc_data = '0; roc_valid = 1'b0; roc_last = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    {tx_k, tx_data}, {2'b11, COMMA});
    chk("rst_ready", {sim_ready, roc_ready}, 2'b00);
    chk("rst_busy",  tx_busy, 0);
    chk("rst_pkt",   pkt_cnt, 0);
    chk("rst_trunc", trunc_err, 0);
    @(negedge clk); tx_rst = 1'b0;

    // Basic packet and mid-packet bubble, cycle by cycle
    model_pkt(16'h0001, 3);
    model_pkt(16'h0010, 2);
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      roc_valid = tbl[i].v; roc_data = tbl[i].d; roc_last = tbl[i].l;
      @(posedge clk); #1;
      chk($sformatf("tbl_tx[%0d]", i),    {tx_k, tx_data}, {tbl[i].ek, tbl[i].ed});
      chk($sformatf("tbl_ready[%0d]", i), roc_ready, tbl[i].er);
      chk($sformatf("tbl_busy[%0d]", i),  tx_busy, tbl[i].eb);
      chk($sformatf("tbl_pkt[%0d]", i),   pkt_cnt, tbl[i].ep);
    end

    // Link not aligned holds off a pending single-word packet
    model_pkt(16'h00A0, 1);
    @(negedge clk);
    link_aligned = 1'b0; roc_valid = 1'b1; roc_data = 16'h00A0; roc_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("nolink_tx",    {tx_k, tx_data}, {2'b11, COMMA});
      chk("nolink_ready", roc_ready, 0);
    end
    @(negedge clk); link_aligned = 1'b1;
    @(posedge clk); #1;
    chk("link_sop",   {tx_k, tx_data}, {2'b11, SOP_WORD});
    chk("link_ready", roc_ready, 1);
    @(posedge clk); #1;
    chk("single_word", {tx_k, tx_data}, {2'b00, 16'h00A0});
    @(negedge clk); roc_valid = 1'b0; roc_last = 1'b0;

    // SIM_EN flips during a ROC packet of exactly MAX_LEN words ending in LAST
    fork
      send_pkt(1'b0, MAX_LEN, 16'h0050, 0);
      begin
        int t = 0;
        @(negedge clk);
        while (!roc_ready && t < 50) begin @(negedge clk); t++; end
        chk("roc_started", roc_ready, 1);
        sim_en = 1'b1; sim_valid = 1'b1; sim_data = 16'h0060; sim_last = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("sim_ready_held", sim_ready, 0);
        end
      end
    join
    send_pkt(1'b1, 1, 16'h0060, 0);
    wait_drain();
    chk("full_len_no_trunc", trunc_err, 0);
    chk("pkt_cnt_a", pkt_cnt, 16'(exp_pkt));

    // Truncation: 6 words with MAX_LEN=4
    send_pkt(1'b0, 6, 16'h0070, 1);
    wait_drain();
    chk("trunc_set", trunc_err, 1);
    chk("pkt_cnt_b", pkt_cnt, 16'(exp_pkt));

    // Random traffic
    repeat (40)
      send_pkt(1'($urandom_range(0, 1)), $urandom_range(1, 6), 16'($urandom), $urandom_range(0, 2));
    wait_drain();
    chk("pkt_cnt_rand", pkt_cnt, 16'(exp_pkt));
    chk("trunc_rand",   trunc_err, exp_trunc);

    // Reset in the middle of a packet
    mon_en = 1'b0;
    @(negedge clk);
    sim_en = 1'b0; roc_valid = 1'b1; roc_data = 16'h0090; roc_last = 1'b0;
    begin
      int t = 0;
      while (!roc_ready && t < 50) begin @(negedge clk); t++; end
      chk("rst_mid_started", roc_ready, 1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); tx_rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_tx",    {tx_k, tx_data}, {2'b11, COMMA});
    chk("rstmid_ready", {sim_ready, roc_ready}, 2'b00);
    chk("rstmid_busy",  tx_busy, 0);
    chk("rstmid_pkt",   pkt_cnt, 0);
    chk("rstmid_trunc", trunc_err, 0);
    @(negedge clk); tx_rst = 1'b0; roc_valid = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      chk("rstmid_no_eop", {tx_k, tx_data}, {2'b11, COMMA});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
